// File: rtl/tt_tanks_pkg.sv
// -----------------------------------------------------------------------------
// tt_tanks_pkg
// Shared definitions for the tiny tanks frame scheduler: scheduler state
// encoding, object IDs, winner encoding, default win score and the saturating
// score increment helper.
// -----------------------------------------------------------------------------
package tt_tanks_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_UPD   = 3'd1,
      ST_COL   = 3'd2,
      ST_SCORE = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam int         ID_W       = 2;

   localparam logic [1:0] OBJ_TANK0  = 2'd0;
   localparam logic [1:0] OBJ_TANK1  = 2'd1;
   localparam logic [1:0] OBJ_SHELL0 = 2'd2;
   localparam logic [1:0] OBJ_SHELL1 = 2'd3;

   localparam logic [1:0] WIN_NONE   = 2'b00;
   localparam logic [1:0] WIN_T0     = 2'b01;
   localparam logic [1:0] WIN_T1     = 2'b10;
   localparam logic [1:0] WIN_DRAW   = 2'b11;

   localparam logic [3:0] WIN_SCORE_DEF = 4'd9;

   // Score increment that never moves past the win limit.
   function automatic logic [3:0] sat_inc(input logic [3:0] s,
                                          input logic       inc,
                                          input logic [3:0] lim);
      if (inc && (s < lim)) return s + 4'd1;
      return s;
   endfunction

endpackage

// File: rtl/tt_tanks_next_obj.sv
// -----------------------------------------------------------------------------
// tt_tanks_next_obj
// Combinational lowest-set-bit encoder over the pending object mask.
// Ports:
//   i_mask  in  NUM_OBJ : pending object mask
//   o_id    out ID_W    : index of the lowest set bit (0 when none)
//   o_none  out 1       : no bit set
// -----------------------------------------------------------------------------
module tt_tanks_next_obj
   import tt_tanks_pkg::*;
#(
   parameter int NUM_OBJ = 4
) (
   input  logic [NUM_OBJ-1:0] i_mask,
   output logic [ID_W-1:0]    o_id,
   output logic               o_none
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_id   = '0;
      o_none = 1'b1;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_id   = ID_W'(i);
            o_none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/tt_tanks_frame_sched.sv
// -----------------------------------------------------------------------------
// tt_tanks_frame_sched
// Per-frame game-logic scheduler. Each accepted frame tick walks the shared
// update engine over the active objects (lowest ID first), runs one collision
// pass, scores the hits and tracks the round / game-over state.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 allows new frames to start
//   frame_tick          vblank pulse
//   start_btn           debounced start level (rising edge restarts from OVER)
//   obj_active          per-object active mask, latched at frame start
//   upd_req/upd_id      update request and object ID; upd_done completes it
//   col_req             collision request; col_done + hit_flags complete it
//   round_rst           one-cycle position reset pulse
//   busy                frame in progress
//   score0/score1       tank scores
//   game_over/winner    end-of-game status
//   fault               sticky timeout / frame-overrun flag
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module tt_tanks_frame_sched
   import tt_tanks_pkg::*;
#(
   parameter int         NUM_OBJ   = 4,
   parameter logic [3:0] WIN_SCORE = WIN_SCORE_DEF,
   parameter logic [7:0] TIMEOUT   = 8'd255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic [NUM_OBJ-1:0] obj_active,
   output logic               upd_req,
   output logic [ID_W-1:0]    upd_id,
   input  logic               upd_done,
   output logic               col_req,
   input  logic               col_done,
   input  logic [1:0]         hit_flags,
   output logic               round_rst,
   output logic               busy,
   output logic [3:0]         score0,
   output logic [3:0]         score1,
   output logic               game_over,
   output logic [1:0]         winner,
   output logic               fault
);

   state_e             r_state;
   logic [NUM_OBJ-1:0] r_act_q;
   logic [7:0]         r_cnt;
   logic [1:0]         r_hits;
   logic               r_btn_q;
   logic               r_upd_req;
   logic [ID_W-1:0]    r_upd_id;
   logic               r_col_req;
   logic               r_round_rst;
   logic               r_busy;
   logic [3:0]         r_score0;
   logic [3:0]         r_score1;
   logic               r_game_over;
   logic [1:0]         r_winner;
   logic               r_fault;

   logic [NUM_OBJ-1:0] w_mask_nxt;
   logic [ID_W-1:0]    w_id;
   logic               w_none;
   logic               w_timeout;
   logic [3:0]         w_s0;
   logic [3:0]         w_s1;
   logic               w_win0;
   logic               w_win1;

   // One encoder serves both frame start (raw mask) and the in-UPD advance
   // (latched mask minus the object just finished), so the next ID is ready
   // on the same edge that retires the current one.
   always_comb begin
      w_mask_nxt = r_act_q & ~(NUM_OBJ'(1) << r_upd_id);
      if (r_state == ST_IDLE) w_mask_nxt = obj_active;
   end

   tt_tanks_next_obj #(.NUM_OBJ(NUM_OBJ)) u_next_obj (
      .i_mask (w_mask_nxt),
      .o_id   (w_id),
      .o_none (w_none)
   );

   // Counter starts at 0 on the first request cycle, so the abort lands after
   // exactly TIMEOUT request cycles without a done.
   assign w_timeout = (r_cnt == TIMEOUT - 8'd1);

   // tank0 hit scores for tank1 and vice versa.
   assign w_s0   = sat_inc(r_score0, r_hits[1], WIN_SCORE);
   assign w_s1   = sat_inc(r_score1, r_hits[0], WIN_SCORE);
   assign w_win0 = (w_s0 == WIN_SCORE);
   assign w_win1 = (w_s1 == WIN_SCORE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_act_q     <= '0;
         r_cnt       <= '0;
         r_hits      <= '0;
         r_btn_q     <= 1'b0;
         r_upd_req   <= 1'b0;
         r_upd_id    <= '0;
         r_col_req   <= 1'b0;
         r_round_rst <= 1'b0;
         r_busy      <= 1'b0;
         r_score0    <= '0;
         r_score1    <= '0;
         r_game_over <= 1'b0;
         r_winner    <= WIN_NONE;
         r_fault     <= 1'b0;
      end else begin
         r_btn_q     <= start_btn;
         r_round_rst <= 1'b0;

         // A tick arriving mid-frame is dropped but remembered as a fault.
         if (frame_tick && r_busy) r_fault <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (frame_tick && ena) begin
                  r_act_q <= obj_active;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  if (w_none) begin
                     r_col_req <= 1'b1;
                     r_state   <= ST_COL;
                  end else begin
                     r_upd_req <= 1'b1;
                     r_upd_id  <= w_id;
                     r_state   <= ST_UPD;
                  end
               end
            end

            ST_UPD: begin
               if (upd_done || w_timeout) begin
                  if (!upd_done) r_fault <= 1'b1;
                  r_act_q <= w_mask_nxt;
                  r_cnt   <= '0;
                  if (w_none) begin
                     r_upd_req <= 1'b0;
                     r_col_req <= 1'b1;
                     r_state   <= ST_COL;
                  end else begin
                     r_upd_id  <= w_id;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            ST_COL: begin
               if (col_done) begin
                  r_hits    <= hit_flags;
                  r_col_req <= 1'b0;
                  r_state   <= ST_SCORE;
               end else if (w_timeout) begin
                  r_hits    <= 2'b00;
                  r_fault   <= 1'b1;
                  r_col_req <= 1'b0;
                  r_state   <= ST_SCORE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            ST_SCORE: begin
               r_score0    <= w_s0;
               r_score1    <= w_s1;
               r_round_rst <= |r_hits;
               r_busy      <= 1'b0;
               if (w_win0 || w_win1) begin
                  r_game_over <= 1'b1;
                  r_winner    <= (w_win0 && w_win1) ? WIN_DRAW :
                                 w_win0             ? WIN_T0   : WIN_T1;
                  r_state     <= ST_OVER;
               end else begin
                  r_state     <= ST_IDLE;
               end
            end

            ST_OVER: begin
               if (start_btn && !r_btn_q) begin
                  r_score0    <= '0;
                  r_score1    <= '0;
                  r_winner    <= WIN_NONE;
                  r_game_over <= 1'b0;
                  r_fault     <= 1'b0;
                  r_round_rst <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign upd_req   = r_upd_req;
   assign upd_id    = r_upd_id;
   assign col_req   = r_col_req;
   assign round_rst = r_round_rst;
   assign busy      = r_busy;
   assign score0    = r_score0;
   assign score1    = r_score1;
   assign game_over = r_game_over;
   assign winner    = r_winner;
   assign fault     = r_fault;

endmodule
